// File: rtl/rx_bit_timer.sv
// rx_bit_timer
// Bit-timing recovery and bit-unstuffing stage of the USB receive path.
// A phase counter, resynchronised on every line transition, selects one
// sample cycle per bit period. At each sample cycle the bit is either
// accepted (shift_enable) or, after STUFF_RUN consecutive accepted ones,
// discarded as a stuffed zero. A stuffed position that carries a one is
// flagged on stuff_error. Accepted bits are counted so that byte_received
// pulses once per BITS_PER_BYTE accepted bits.

module rx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT  = 8,
  parameter int unsigned SAMPLE_POINT  = 3,
  parameter int unsigned BITS_PER_BYTE = 8,
  parameter int unsigned STUFF_RUN     = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic rcving,
  input  logic d_edge,
  input  logic d_orig,
  output logic shift_enable,
  output logic byte_received,
  output logic stuff_error
);

  // The phase counter spans one bit period, the ones counter must be able
  // to hold STUFF_RUN itself, and the bit counter spans one byte.
  localparam int unsigned PW = (CLKS_PER_BIT  > 1) ? $clog2(CLKS_PER_BIT)  : 1;
  localparam int unsigned OW = $clog2(STUFF_RUN + 1);
  localparam int unsigned BW = (BITS_PER_BYTE > 1) ? $clog2(BITS_PER_BYTE) : 1;

  localparam logic [PW-1:0] PHASE_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_SAMPLE = PW'(SAMPLE_POINT);
  localparam logic [OW-1:0] ONES_LIMIT   = OW'(STUFF_RUN);
  localparam logic [BW-1:0] BIT_LAST     = BW'(BITS_PER_BYTE - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          byte_q, byte_d;
  logic          stuff_err_q, stuff_err_d;

  logic sample;
  logic stuffed;
  logic accept;

  // Sample-point decode from registered phase only, so an edge arriving in
  // the sample cycle itself still lets that sample through.
  always_comb begin
    sample  = 1'b0;
    stuffed = 1'b0;
    accept  = 1'b0;
    if (rcving && (phase_q == PHASE_SAMPLE)) begin
      sample = 1'b1;
      if (ones_q == ONES_LIMIT) begin
        stuffed = 1'b1;
      end else begin
        accept = 1'b1;
      end
    end
  end

  assign shift_enable  = accept;
  assign byte_received = byte_q;
  assign stuff_error   = stuff_err_q;

  // Phase tracking: an edge marks phase 0 in the current cycle, otherwise
  // the phase free-runs and wraps once per bit period.
  always_comb begin
    phase_d = phase_q;
    if (!rcving) begin
      phase_d = '0;
    end else if (d_edge) begin
      phase_d = PW'(1);
    end else if (phase_q == PHASE_LAST) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PW'(1);
    end
  end

  // Run-length of accepted ones; a stuffed position always restarts the run,
  // and byte boundaries deliberately do not touch it.
  always_comb begin
    ones_d = ones_q;
    if (!rcving) begin
      ones_d = '0;
    end else if (stuffed) begin
      ones_d = '0;
    end else if (accept) begin
      ones_d = d_orig ? (ones_q + OW'(1)) : '0;
    end
  end

  // Accepted-bit counter within the current byte, plus the completion flag
  // raised on the last accepted bit of a byte.
  always_comb begin
    bit_d  = bit_q;
    byte_d = 1'b0;
    if (!rcving) begin
      bit_d = '0;
    end else if (accept) begin
      if (bit_q == BIT_LAST) begin
        bit_d  = '0;
        byte_d = 1'b1;
      end else begin
        bit_d = bit_q + BW'(1);
      end
    end
  end

  // A one in a position that must hold a stuffed zero is a stuffing error.
  always_comb begin
    stuff_err_d = 1'b0;
    if (stuffed && d_orig) begin
      stuff_err_d = 1'b1;
    end
  end

  // State and registered strobes, cleared immediately by reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_q     <= '0;
      ones_q      <= '0;
      bit_q       <= '0;
      byte_q      <= 1'b0;
      stuff_err_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      ones_q      <= ones_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      stuff_err_q <= stuff_err_d;
    end
  end

  // The raw sample decode is kept for readability of the stuffing logic;
  // it is fully covered by the stuffed/accept split.
  logic unusedSample;
  assign unusedSample = sample;

endmodule

// File: doc/rx_bit_timer.md
Name: rx_bit_timer

Overview:
- Bit-timing and bit-unstuffing stage of the USB receive path, placed alongside the NRZI decoder.
- Recovers bit timing from the oversampled line using d_edge, and generates the shift_enable strobe that the decoder and the receive shift register consume.
- Removes stuffed zeros by withholding shift_enable for them, flags stuffing violations, and signals byte completion to the receive controller.

Parameters:
- CLKS_PER_BIT, 8, clock cycles per USB bit period (>=4).
- SAMPLE_POINT, 3, phase value at which a bit is sampled (0 < SAMPLE_POINT < CLKS_PER_BIT-1).
- BITS_PER_BYTE, 8, accepted bits per byte_received pulse.
- STUFF_RUN, 6, consecutive ones after which the next bit is a stuffed zero.

Ports:
- clk  input  1  system clock, CLKS_PER_BIT x bit rate.
- n_rst  input  1  asynchronous active-low reset.
- rcving  input  1  high while a packet is being received; low clears the timing state.
- d_edge  input  1  one-cycle pulse on any line transition (synchronised upstream).
- d_orig  input  1  decoded (NRZI-removed) bit value, valid at the sample strobe.
- shift_enable  output  1  one-cycle strobe; accept d_orig as a data bit.
- byte_received  output  1  one-cycle pulse after BITS_PER_BYTE accepted bits.
- stuff_error  output  1  one-cycle pulse; the expected stuffed bit was a one.

Behaviour:
- Reset (n_rst low, asynchronous): phase=0, ones_cnt=0, bit_cnt=0, byte_received=0, stuff_error=0.
  - shift_enable is 0 because rcving gating and phase=0 are not the sample point.
- Reset mid-packet returns all state to these values immediately.
- Phase counter, width clog2(CLKS_PER_BIT):
  - rcving=0: phase<=0, ones_cnt<=0, bit_cnt<=0, no strobes.
  - rcving=1 and d_edge=1: phase<=1. The edge cycle counts as phase 0 (resync).
  - rcving=1 and d_edge=0: phase<=phase+1, wrapping CLKS_PER_BIT-1 -> 0.
- Sample cycle: rcving=1 and registered phase==SAMPLE_POINT. It is computed from the current register, so a d_edge in the same cycle does not cancel it.
- Stuffing at each sample cycle:
  - If ones_cnt==STUFF_RUN, the bit is stuffed:
    - shift_enable=0, ones_cnt<=0, bit_cnt unchanged.
    - If d_orig==1, stuff_error<=1 for one cycle (registered; visible the next cycle).
  - Otherwise shift_enable=1 (combinational from registered state).
    - ones_cnt<=d_orig ? ones_cnt+1 : 0.
    - bit_cnt advances.
- ones_cnt never exceeds STUFF_RUN.
- Byte count:
  - bit_cnt counts accepted shift_enables.
  - On the BITS_PER_BYTE-th: bit_cnt<=0 and byte_received<=1 for exactly one cycle, the cycle after that shift_enable.
  - ones_cnt is not reset at byte boundaries; stuffing spans bytes.
- Latency:
  - An edge in cycle t gives a sample in cycle t+SAMPLE_POINT.
  - With no edges, samples repeat every CLKS_PER_BIT cycles.
- rcving falling: state clears on the next clock; a byte_received or stuff_error already registered still completes its single cycle.
- Edge every cycle: phase stays 1 and never reaches SAMPLE_POINT (>1), so no strobe. This is legal; the bench must not hang.

Test Plan:
1. Reset/idle:
   - n_rst low mid-packet (phase=5, bit_cnt=4) -> all outputs 0 immediately.
   - After release with rcving=0 for 20 cycles -> no strobes.
2. Free-running timing:
   - rcving rises at cycle 0, no edges -> shift_enable at cycles 3, 11, 19, 27, each exactly one cycle wide.
3. Resync:
   - rcving high, d_edge pulsed at cycle where phase==6 -> next shift_enable 3 cycles after the edge, then every 8 cycles.
4. Byte completion:
   - Eight samples with d_orig pattern 0,1,0,1,0,1,0,0 -> byte_received high only on the cycle after the 8th shift_enable.
   - bit_cnt=0 afterwards; stuff_error stays 0.
5. Legal stuffing:
   - Six samples d_orig=1, seventh d_orig=0 -> 6 shift_enables, seventh sample has shift_enable=0, no stuff_error.
   - byte_received fires only after two further accepted bits.
6. Stuff violation:
   - Six ones then a seventh sample d_orig=1 -> stuff_error one-cycle pulse the cycle after that sample, no shift_enable on it, ones_cnt=0.
